// File: rtl/multi_debouncer_pkg.sv
// ============================================================================
// Module      : multi_debouncer_pkg
// Description : Shared constants for the multi-channel button debouncer.
//               Timing defaults are in clk_i cycles at 100 MHz.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multi_debouncer_pkg;

    // 500 us lockout after an accepted change
    localparam int DEF_LOCK_CYC   = 50_000;
    // 250 ms hold before the first auto-repeat, then one repeat every 50 ms
    localparam int DEF_RPT_DELAY  = 25_000_000;
    localparam int DEF_RPT_PERIOD = 5_000_000;

    // Channel assignment on the game board
    localparam int CH_UP     = 0;
    localparam int CH_DOWN   = 1;
    localparam int CH_LEFT   = 2;
    localparam int CH_RIGHT  = 3;
    localparam int CH_CENTER = 4;

    // Bits needed to hold values 0..max_val (never less than one bit)
    function automatic int width_for(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multi_debouncer_debounce_ch.sv
// ============================================================================
// Module      : debounce_ch
// Description : One button channel: 2-flop synchroniser, accept-then-lockout
//               filter, debounced level and registered rise/fall/press pulses.
//               Auto-repeat counter built only when
//               MULTI_DEBOUNCER_AUTOREPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_ch
    import multi_debouncer_pkg::*;
#(
    parameter int LOCK_CYC   = DEF_LOCK_CYC,
    parameter int CNT_W      = 20
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
    ,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD,
    parameter int RPT_W      = 26
`endif
) (
    input  logic clk_i,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_press,
    // press value that will be registered on the next edge, for the
    // top-level OR so any_press lines up with the per-channel pulse
    output logic o_press_nxt
);

    localparam logic [CNT_W-1:0] c_LOCK_LOAD = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0] c_LOCK_ONE  = CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_press;
    logic [CNT_W-1:0] r_lock_cnt;

    logic             w_accept;
    logic             w_press_nxt;

    // A change is taken the moment the synchronised input differs from the
    // level, provided the previous change's lockout has run out.
    assign w_accept = (r_s2 != r_level) && (r_lock_cnt == '0);

    // Two-flop synchroniser for the asynchronous pin
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
        end
    end

    // Accept-then-lockout filter with its rise/fall pulses
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            r_level    <= 1'b0;
            r_lock_cnt <= '0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
        end else begin
            r_rise <= w_accept &&  r_s2;
            r_fall <= w_accept && !r_s2;
            if (w_accept) begin
                r_level    <= r_s2;
                r_lock_cnt <= c_LOCK_LOAD;
            end else if (r_lock_cnt != '0) begin
                r_lock_cnt <= r_lock_cnt - c_LOCK_ONE;
            end
        end
    end

`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
    localparam logic [RPT_W-1:0] c_RPT_DELAY_LOAD  = RPT_W'(RPT_DELAY - 1);
    localparam logic [RPT_W-1:0] c_RPT_PERIOD_LOAD = RPT_W'(RPT_PERIOD - 1);
    localparam logic [RPT_W-1:0] c_RPT_ONE         = RPT_W'(1);

    logic [RPT_W-1:0] r_rpt_cnt;
    logic             w_tick;

    // While held, an expired counter produces a repeat tick. With the level
    // high any accept is a fall, and a fall suppresses the tick.
    assign w_tick      = r_level && !w_accept && (r_rpt_cnt == '0);
    assign w_press_nxt = (w_accept && r_s2) || w_tick;

    // Repeat counter: armed on rise, reloaded on each tick, cleared on fall
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            r_rpt_cnt <= '0;
        end else if (w_accept) begin
            r_rpt_cnt <= r_s2 ? c_RPT_DELAY_LOAD : '0;
        end else if (r_level) begin
            if (r_rpt_cnt == '0) begin
                r_rpt_cnt <= c_RPT_PERIOD_LOAD;
            end else begin
                r_rpt_cnt <= r_rpt_cnt - c_RPT_ONE;
            end
        end
    end
`else
    // Without auto-repeat a press is exactly a rise
    assign w_press_nxt = w_accept && r_s2;
`endif

    // Registered press pulse
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            r_press <= 1'b0;
        end else begin
            r_press <= w_press_nxt;
        end
    end

    assign o_level     = r_level;
    assign o_rise      = r_rise;
    assign o_fall      = r_fall;
    assign o_press     = r_press;
    assign o_press_nxt = w_press_nxt;

endmodule

`default_nettype wire

// File: rtl/multi_debouncer.sv
// ============================================================================
// Module      : multi_debouncer
// Description : N-channel push-button conditioner. One independent
//               debounce_ch per button plus a registered OR of all press
//               pulses. Optional auto-repeat: MULTI_DEBOUNCER_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int N_CH       = 5,
    parameter int LOCK_CYC   = DEF_LOCK_CYC,
    parameter int CNT_W      = 20,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD,
    parameter int RPT_W      = 26
) (
    input  logic            clk_i,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] btn_level_o,
    output logic [N_CH-1:0] btn_rise_o,
    output logic [N_CH-1:0] btn_fall_o,
    output logic [N_CH-1:0] btn_press_o,
    output logic            any_press_o
);

    localparam int c_RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;

    logic [N_CH-1:0] w_press_nxt;
    logic            r_any_press;

    // The lockout reload value has to fit the lock counter
    if ((LOCK_CYC < 1) || (width_for(LOCK_CYC - 1) > CNT_W)) begin : g_bad_lock
        $error("multi_debouncer: LOCK_CYC=%0d out of range for CNT_W=%0d",
               LOCK_CYC, CNT_W);
    end

    // The repeat reload values have to fit the repeat counter
    if ((RPT_DELAY < 1) || (RPT_PERIOD < 1) ||
        (width_for(c_RPT_MAX - 1) > RPT_W)) begin : g_bad_rpt
        $error("multi_debouncer: RPT_DELAY/RPT_PERIOD do not fit RPT_W=%0d",
               RPT_W);
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_ch #(
            .LOCK_CYC   (LOCK_CYC),
            .CNT_W      (CNT_W)
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
            ,
            .RPT_DELAY  (RPT_DELAY),
            .RPT_PERIOD (RPT_PERIOD),
            .RPT_W      (RPT_W)
`endif
        ) u_ch (
            .clk_i       (clk_i),
            .reset       (reset),
            .i_btn       (btn_i[g]),
            .o_level     (btn_level_o[g]),
            .o_rise      (btn_rise_o[g]),
            .o_fall      (btn_fall_o[g]),
            .o_press     (btn_press_o[g]),
            .o_press_nxt (w_press_nxt[g])
        );
    end

    // OR of the next-cycle press values so any_press rises with btn_press_o
    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |w_press_nxt;
        end
    end

    assign any_press_o = r_any_press;

endmodule

`default_nettype wire

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- N-channel push-button conditioner for the game's directional and centre buttons. Generalised successor of the single-channel debouncer.
- Per channel: 2-flop synchroniser, accept-then-lockout filter, debounced level, and one-cycle rise/fall/press pulses.
- Sits between the board button pins and the game-control FSM. The FSM consumes press pulses only, so it needs no edge detection of its own.

Parameters:
- N_CH, 5, number of independent button channels.
- LOCK_CYC, 50000, lockout length in clk_i cycles after an accepted change; legal range 1..2^CNT_W.
- CNT_W, 20, lockout counter width.
- RPT_DELAY, 25000000, cycles of continuous hold before the first auto-repeat pulse; used only with AUTOREPEAT_EN.
- RPT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses; used only with AUTOREPEAT_EN.
- RPT_W, 26, repeat counter width; must hold max(RPT_DELAY, RPT_PERIOD)-1.

Ports:
- clk_i, in, 1, system clock; the single clock domain.
- reset, in, 1, asynchronous, active-low reset.
- btn_i, in, N_CH, raw asynchronous button inputs; bit k is channel k.
- btn_level_o, out, N_CH, debounced level.
- btn_rise_o, out, N_CH, one-cycle pulse when the debounced level goes 0->1.
- btn_fall_o, out, N_CH, one-cycle pulse when the debounced level goes 1->0.
- btn_press_o, out, N_CH, one-cycle press event: the rise, plus auto-repeat ticks when that feature is enabled.
- any_press_o, out, 1, OR-reduction of btn_press_o; registered in the same cycle as btn_press_o.

Behaviour:
- Reset (reset=0, asynchronous): the following are cleared to 0 immediately:
  - synchroniser flops, all counters;
  - btn_level_o, btn_rise_o, btn_fall_o, btn_press_o, any_press_o.
- Release of reset is synchronous to clk_i; sync flops start sampling on the first edge after release.
- Channels are fully independent. There is no shared state between channels except the any_press_o reduction.
- Synchroniser: s1 <= btn_i[k], s2 <= s1.
- Filter, evaluated each edge:
  - If s2 != level and lock_cnt == 0: level <= s2, lock_cnt <= LOCK_CYC-1, and the matching rise/fall pulse is asserted for exactly that cycle.
  - Else if lock_cnt != 0: lock_cnt decrements, and level and s2 changes are ignored.
- Latency: a btn_i change that is stable before edge E appears on btn_level_o and the pulse after edge E+2. That is 3 edges when unlocked.
- Lockout: the earliest next accepted change is LOCK_CYC cycles after the previous one. With LOCK_CYC=1 there is no lockout; a change is accepted at most once per cycle.
- Input changes during lockout are not queued. The state of s2 at lockout expiry is what gets compared.
- A glitch shorter than 2 cycles may still be accepted if it is sampled by s1 (accept-immediately filter). This is intended: it gives the lowest latency.
- Rise and fall are never both high on one channel in the same cycle.
- All pulse outputs are registered and deassert the following cycle unless re-triggered.
- Elaboration: LOCK_CYC-1 must fit in CNT_W, or the design raises a $error.

Optional Feature:
- Macro: MULTI_DEBOUNCER_AUTOREPEAT_EN.
- Defined:
  - Each channel has an rpt_cnt. On rise, rpt_cnt <= RPT_DELAY-1.
  - While level=1, rpt_cnt decrements. When rpt_cnt == 0 and level=1, btn_press_o[k] pulses and rpt_cnt <= RPT_PERIOD-1.
  - A fall or reset clears rpt_cnt and stops repeats. No repeat pulse is generated in the fall cycle.
  - btn_press_o = rise | repeat tick.
- Undefined: btn_press_o is identical to btn_rise_o, no rpt_cnt logic is generated, and the RPT_* parameters are ignored.

Decomposition:
- Package multi_debouncer_pkg holds the default constants, in clk_i cycles at 100 MHz:
  - DEF_LOCK_CYC;
  - DEF_RPT_DELAY and DEF_RPT_PERIOD;
  - a clog2-based width helper;
  - channel index constants CH_UP=0, CH_DOWN=1, CH_LEFT=2, CH_RIGHT=3, CH_CENTER=4.
- Sub-module debounce_ch (one channel):
  - contents: sync flops, lock counter, optional repeat counter;
  - outputs: level, rise, fall, press.
- Top level: generate-loop instance of debounce_ch per channel, plus the registered any_press OR.

Test Plan (N_CH=2, LOCK_CYC=8, CNT_W=4, RPT_DELAY=20, RPT_PERIOD=6, RPT_W=5):
- Reset: reset=0 mid-run with btn_level_o=2'b11 -> all outputs 0 asynchronously, before the next clk_i edge. After release with btn_i=0, outputs stay 0.
- Clean press: btn_i[0] 0->1 before edge E -> btn_level_o[0]=1 and btn_rise_o[0]=btn_press_o[0]=any_press_o=1 after E+2, for 1 cycle only.
- Bounce: btn_i[0] toggles every cycle for 6 cycles after an accepted rise -> no further pulses. At lockout expiry (8 cycles after the accept), the level follows the current s2.
- Release and lockout: a release 3 cycles after an accepted press -> fall pulse exactly 8 cycles after the rise. A release 10 cycles after the press -> fall at release+3 edges.
- Independence: ch0 and ch1 pressed on the same edge -> both rise pulses in the same cycle, and any_press_o=1 for a single cycle. Ch1 bounce does not affect ch0 lockout.
- Auto-repeat (macro defined): hold ch0 for 40 cycles after rise -> press pulses at rise+20, +26, +32, +38. Release -> no further pulses. Without the macro -> btn_press_o == btn_rise_o on every cycle.
